// File: rtl/bus_slave_regfile.sv
// 16-word register file bus responder with a programmable number of wait states.
// Accepts an access on chip select + address strobe, waits WAIT_CYCLES cycles, then
// pulses an active-low ready for one cycle with read data (zero for writes).
// s_rdy_ and s_rd_data come straight from flops so the slave-side mux never sees
// input-to-output glitches.
module bus_slave_regfile #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned WORD_ADDR_W = 30,
    parameter int unsigned WORD_DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic                   s_cs_,
    input  logic                   s_as_,
    input  logic                   s_rw,
    input  logic [WORD_ADDR_W-1:0] s_addr,
    input  logic [WORD_DATA_W-1:0] s_wr_data,
    output logic [WORD_DATA_W-1:0] s_rd_data,
    output logic                   s_rdy_
);

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    // The wait counter is 4 bits wide, so larger wait counts cannot be represented.
    if (WAIT_CYCLES > 15) begin : g_bad_wait
        $error("bus_slave_regfile: WAIT_CYCLES must be in 0..15");
    end
    if (WORD_ADDR_W < 4) begin : g_bad_addr
        $error("bus_slave_regfile: WORD_ADDR_W must be at least 4");
    end

    localparam logic [3:0] WaitLoad = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [3:0]             idx_q, idx_d;
    logic                   rw_q, rw_d;
    logic [WORD_DATA_W-1:0] wdata_q, wdata_d;
    logic [WORD_DATA_W-1:0] regs [16];
    logic [WORD_DATA_W-1:0] rd_data_d;
    logic                   rdy_d;

    // Upper address bits are decoded elsewhere; only the register index matters here.
    logic unused_addr;
    assign unused_addr = ^s_addr[WORD_ADDR_W-1:4];

    // Next-state logic: accept, count wait states (abort on strobe loss), acknowledge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (s_cs_ == ENABLE_ && s_as_ == ENABLE_) begin
                    idx_d   = s_addr[3:0];
                    rw_d    = s_rw;
                    wdata_d = s_wr_data;
                    if (WAIT_CYCLES == 0) begin
                        state_d = StAck;
                    end else begin
                        cnt_d   = WaitLoad;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (s_cs_ == DISABLE_ || s_as_ == DISABLE_) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd0) begin
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output values are computed for the cycle being entered so they can be registered.
    always_comb begin
        rdy_d     = (state_d == StAck) ? ENABLE_ : DISABLE_;
        rd_data_d = '0;
        if (state_d == StAck && rw_d == READ) begin
            rd_data_d = regs[idx_d];
        end
    end

    // Control state, latched access and registered bus outputs.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            idx_q     <= 4'd0;
            rw_q      <= READ;
            wdata_q   <= '0;
            s_rdy_    <= DISABLE_;
            s_rd_data <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rw_q      <= rw_d;
            wdata_q   <= wdata_d;
            s_rdy_    <= rdy_d;
            s_rd_data <= rd_data_d;
        end
    end

    // Register file: writes commit at the edge that ends the acknowledge cycle.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else if (state_q == StAck && rw_q == WRITE) begin
            regs[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_bus_slave_regfile.sv
// Scoreboard bench: three responders with 0, 1 and 3 wait states. Stimulus pushes
// the expected ready cycle and read data; a negedge monitor pops and compares.
module tb_bus_slave_regfile;

    typedef struct packed {
        int unsigned cyc;
        logic [31:0] data;
    } exp_t;

    localparam int unsigned WC [3] = '{0, 1, 3};

    logic        clk = 1'b0;
    logic        reset_;
    logic        s_cs_     [3];
    logic        s_as_     [3];
    logic        s_rw      [3];
    logic [29:0] s_addr    [3];
    logic [31:0] s_wr_data [3];
    logic [31:0] s_rd_data [3];
    logic        s_rdy_    [3];

    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;
    bit          mon_en = 1'b0;
    logic [31:0] mem [3][16];
    exp_t        expq [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_slave_regfile #(.WAIT_CYCLES(0), .WORD_ADDR_W(30), .WORD_DATA_W(32)) u_dut0 (
        .clk(clk), .reset_(reset_), .s_cs_(s_cs_[0]), .s_as_(s_as_[0]), .s_rw(s_rw[0]),
        .s_addr(s_addr[0]), .s_wr_data(s_wr_data[0]), .s_rd_data(s_rd_data[0]),
        .s_rdy_(s_rdy_[0]));
    bus_slave_regfile #(.WAIT_CYCLES(1), .WORD_ADDR_W(30), .WORD_DATA_W(32)) u_dut1 (
        .clk(clk), .reset_(reset_), .s_cs_(s_cs_[1]), .s_as_(s_as_[1]), .s_rw(s_rw[1]),
        .s_addr(s_addr[1]), .s_wr_data(s_wr_data[1]), .s_rd_data(s_rd_data[1]),
        .s_rdy_(s_rdy_[1]));
    bus_slave_regfile #(.WAIT_CYCLES(3), .WORD_ADDR_W(30), .WORD_DATA_W(32)) u_dut3 (
        .clk(clk), .reset_(reset_), .s_cs_(s_cs_[2]), .s_as_(s_as_[2]), .s_rw(s_rw[2]),
        .s_addr(s_addr[2]), .s_wr_data(s_wr_data[2]), .s_rd_data(s_rd_data[2]),
        .s_rdy_(s_rdy_[2]));

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    // Monitor: every ready pulse must match the head of the queue; otherwise idle bus.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            for (int d = 0; d < 3; d++) begin
                if (s_rdy_[d] === 1'b0) begin
                    if (expq[d].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rdy dut%0d: got rdy 0 at cycle %0d, expected 1",
                                 d, cyc);
                    end else begin
                        e = expq[d].pop_front();
                        chk($sformatf("rdy_cycle dut%0d", d), cyc, e.cyc);
                        chk($sformatf("rd_data dut%0d", d), s_rd_data[d], e.data);
                    end
                end else begin
                    chk($sformatf("idle_rdy dut%0d", d), {31'b0, s_rdy_[d]}, 32'd1);
                    chk($sformatf("idle_data dut%0d", d), s_rd_data[d], 32'd0);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset_ = 1'b0;
        for (int d = 0; d < 3; d++) begin
            s_cs_[d] = 1'b1;
            s_as_[d] = 1'b1;
        end
        repeat (n) @(posedge clk);
        #1;
        mon_en = 1'b1;
        reset_ = 1'b1;
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 16; i++) mem[d][i] = 32'h0;
    endtask

    // Master access; called one time unit after a rising edge with the slave idle.
    task automatic access(input int d, input bit rw, input logic [29:0] addr,
                          input logic [31:0] wd);
        exp_t e;
        int   idx;
        bit   seen;
        idx    = int'(addr[3:0]);
        e.cyc  = cyc + 1 + WC[d];
        e.data = rw ? mem[d][idx] : 32'h0;
        expq[d].push_back(e);
        if (!rw) mem[d][idx] = wd;
        s_cs_[d] = 1'b0;
        s_as_[d] = 1'b0;
        s_rw[d] = rw;
        s_addr[d] = addr;
        s_wr_data[d] = wd;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (s_rdy_[d] === 1'b0) begin
                seen = 1'b1;
            end else if (i >= 1) begin
                // Past the accept edge: these changes must not affect the access.
                s_rw[d] = $urandom_range(0, 1);
                s_addr[d] = 30'($urandom);
                s_wr_data[d] = $urandom;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rdy_timeout dut%0d: got no rdy, expected rdy at cycle %0d", d, e.cyc);
        end
        @(posedge clk);
        #1;
        s_cs_[d] = 1'b1;
        s_as_[d] = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [29:0] a;
        reset_ = 1'b0;
        for (int d = 0; d < 3; d++) begin
            s_cs_[d] = 1'b1;
            s_as_[d] = 1'b1;
            s_rw[d] = 1'b1;
            s_addr[d] = '0;
            s_wr_data[d] = '0;
        end
        @(posedge clk);
        #1;
        do_reset(2);

        // Reset values visible through reads.
        for (int d = 0; d < 3; d++) access(d, 1'b1, 30'd5, 32'h0);

        // Write/readback with one wait state.
        access(1, 1'b0, 30'd3, 32'hDEADBEEF);
        access(1, 1'b1, 30'd3, 32'h0);

        // Zero-wait back-to-back.
        access(0, 1'b0, 30'd0, 32'h11111111);
        access(0, 1'b0, 30'd15, 32'h22222222);
        access(0, 1'b1, 30'd0, 32'h0);
        access(0, 1'b1, 30'd15, 32'h0);

        // Abort by dropping the address strobe in the second wait cycle.
        s_cs_[2] = 1'b0; s_as_[2] = 1'b0; s_rw[2] = 1'b0;
        s_addr[2] = 30'd7; s_wr_data[2] = 32'hCAFEF00D;
        idle(1);
        idle(1);
        s_as_[2] = 1'b1;
        idle(1);
        s_cs_[2] = 1'b1;
        idle(5);
        access(2, 1'b1, 30'd7, 32'h0);

        // Abort by dropping chip select during the single wait cycle.
        s_cs_[1] = 1'b0; s_as_[1] = 1'b0; s_rw[1] = 1'b0;
        s_addr[1] = 30'd3; s_wr_data[1] = 32'h0BADF00D;
        idle(1);
        s_cs_[1] = 1'b1;
        idle(1);
        s_as_[1] = 1'b1;
        idle(4);
        access(1, 1'b1, 30'd3, 32'h0);

        // Reset during a wait state of a write.
        s_cs_[2] = 1'b0; s_as_[2] = 1'b0; s_rw[2] = 1'b0;
        s_addr[2] = 30'd2; s_wr_data[2] = 32'h12345678;
        idle(2);
        do_reset(2);
        idle(5);
        access(2, 1'b1, 30'd2, 32'h0);

        // Address wrap and an unselected slave.
        access(1, 1'b0, 30'h11, 32'hA5A5A5A5);
        access(1, 1'b1, 30'h01, 32'h0);
        s_cs_[0] = 1'b1; s_as_[0] = 1'b0; s_rw[0] = 1'b1; s_addr[0] = 30'd0;
        idle(10);
        s_as_[0] = 1'b1;
        idle(1);

        // Randomized traffic with upper address noise and occasional gaps.
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 40; n++) begin
                a = 30'($urandom);
                if ($urandom_range(0, 1) == 1) a[3:0] = 4'($urandom_range(0, 3));
                access(d, 1'($urandom_range(0, 1)), a, $urandom);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end

        idle(8);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("pending_expect dut%0d", d), 32'(expq[d].size()), 32'd0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
